// File: rtl/config_chain_loader_pkg.sv
// Shared configuration-chain definitions: loader states and per-tile chain lengths.
// The default chain length is the sum of the config bits of every tile on the chain.
package config_chain_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    LOAD,
    DONE
  } load_state_e;

  localparam int unsigned IO_TILE_BITS    = 4;
  localparam int unsigned LOGIC_TILE_BITS = 16;

  localparam int unsigned NUM_IO_TILES    = 9;
  localparam int unsigned NUM_LOGIC_TILES = 0;

  localparam int unsigned DEFAULT_CHAIN_LENGTH =
    NUM_IO_TILES * IO_TILE_BITS + NUM_LOGIC_TILES * LOGIC_TILE_BITS;

endpackage

// File: rtl/config_chain_loader_serializer.sv
// Word-wide shift register with a remaining-bit count. The next-state LSB and flags
// are exported so the loader can register its chain outputs one cycle ahead.
module config_word_serializer #(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  load,
  input  logic                  shift,
  input  logic [WORD_WIDTH-1:0] load_data,
  output logic                  empty,
  output logic                  nxt_empty,
  output logic                  nxt_last,
  output logic                  nxt_lsb
);

  localparam int unsigned REM_W = $clog2(WORD_WIDTH + 1);

  logic [WORD_WIDTH-1:0] sreg, sreg_nxt;
  logic [REM_W-1:0]      remain, remain_nxt;

  // A load on the same edge as the last bit shifting out replaces the register,
  // which is what gives back-to-back words with no bubble.
  always_comb begin
    sreg_nxt   = sreg;
    remain_nxt = remain;
    if (flush) begin
      sreg_nxt   = '0;
      remain_nxt = '0;
    end else if (load) begin
      sreg_nxt   = load_data;
      remain_nxt = REM_W'(WORD_WIDTH);
    end else if (shift && (remain != '0)) begin
      sreg_nxt   = sreg >> 1;
      remain_nxt = remain - REM_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sreg   <= '0;
      remain <= '0;
    end else begin
      sreg   <= sreg_nxt;
      remain <= remain_nxt;
    end
  end

  always_comb begin
    empty     = (remain == '0);
    nxt_empty = (remain_nxt == '0);
    nxt_last  = (remain_nxt == REM_W'(1));
    nxt_lsb   = sreg_nxt[0];
  end

endmodule

// File: rtl/config_chain_loader.sv
// Serial configuration-chain loader: clears the chain, then shifts bitstream words
// into it LSB-first, one bit per clock, and reports progress and completion.
module config_chain_loader
  import config_chain_loader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH   = 8,
  parameter int unsigned CHAIN_LENGTH = DEFAULT_CHAIN_LENGTH,
  parameter int unsigned CLEAR_CYCLES = 2,
  parameter int unsigned CNT_W        = $clog2(CHAIN_LENGTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_out,
  output logic                  config_enable,
  output logic                  config_nreset,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      bit_count
);

  localparam int unsigned       CLR_W      = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(CHAIN_LENGTH);
  localparam logic [CNT_W-1:0]  LAST_INDEX = CNT_W'(CHAIN_LENGTH - 1);

  load_state_e      state, state_nxt;
  logic [CLR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic [CNT_W-1:0] bit_count_nxt;

  logic take_start, shift, final_shift, xfer, flush;
  logic ser_empty, ser_nxt_empty, ser_nxt_last, ser_nxt_lsb;
  logic ready_nxt, out_nxt, enable_nxt, nreset_nxt, busy_nxt, done_nxt;

  config_word_serializer #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_serializer (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .load      (xfer),
    .shift     (shift),
    .load_data (word_data),
    .empty     (ser_empty),
    .nxt_empty (ser_nxt_empty),
    .nxt_last  (ser_nxt_last),
    .nxt_lsb   (ser_nxt_lsb)
  );

  always_comb begin
    take_start  = start && ((state == IDLE) || (state == DONE));
    shift       = (state == LOAD) && !ser_empty;
    final_shift = shift && (bit_count == LAST_INDEX);
    xfer        = word_valid && word_ready && !final_shift;
    // Leftover upper bits of the last word are dropped when the chain fills.
    flush       = take_start || final_shift;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      clr_cnt       <= '0;
      bit_count     <= '0;
      word_ready    <= 1'b0;
      config_out    <= 1'b0;
      config_enable <= 1'b0;
      config_nreset <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      clr_cnt       <= clr_cnt_nxt;
      bit_count     <= bit_count_nxt;
      word_ready    <= ready_nxt;
      config_out    <= out_nxt;
      config_enable <= enable_nxt;
      config_nreset <= nreset_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start)                     state_nxt = CLEAR;
      CLEAR:      if (clr_cnt == CLR_W'(1))      state_nxt = LOAD;
      LOAD:       if (final_shift)               state_nxt = DONE;
    endcase
  end

  always_comb begin
    clr_cnt_nxt = clr_cnt;
    if (take_start) begin
      clr_cnt_nxt = CLR_W'(CLEAR_CYCLES);
    end else if ((state == CLEAR) && (clr_cnt != '0)) begin
      clr_cnt_nxt = clr_cnt - CLR_W'(1);
    end

    bit_count_nxt = bit_count;
    if (take_start) begin
      bit_count_nxt = '0;
    end else if (shift && (bit_count != FULL_COUNT)) begin
      bit_count_nxt = bit_count + CNT_W'(1);
    end
  end

  // Outputs are computed from next-cycle state so every port comes straight from a flop.
  always_comb begin
    busy_nxt   = (state_nxt == CLEAR) || (state_nxt == LOAD);
    done_nxt   = (state_nxt == DONE);
    enable_nxt = (state_nxt == LOAD) && !ser_nxt_empty;
    out_nxt    = enable_nxt ? ser_nxt_lsb : config_out;

    nreset_nxt = config_nreset;
    if (state_nxt == CLEAR) begin
      nreset_nxt = 1'b0;
    end else if (state_nxt == LOAD) begin
      nreset_nxt = 1'b1;
    end

    ready_nxt = (state_nxt == LOAD) &&
                (ser_nxt_empty || (ser_nxt_last && (bit_count_nxt < LAST_INDEX)));
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader with a 9 x 4-bit IO-tile chain model.
module tb_config_chain_loader;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] word_data;
  logic       word_valid;
  logic       word_ready;
  logic       config_out;
  logic       config_enable;
  logic       config_nreset;
  logic       busy;
  logic       done;
  logic [5:0] bit_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  words [5];
  logic [35:0] exp_stream;
  logic [35:0] chain;

  config_chain_loader #(
    .WORD_WIDTH   (8),
    .CHAIN_LENGTH (36),
    .CLEAR_CYCLES (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .word_data     (word_data),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .config_out    (config_out),
    .config_enable (config_enable),
    .config_nreset (config_nreset),
    .busy          (busy),
    .done          (done),
    .bit_count     (bit_count)
  );

  always #5 clock = ~clock;

  // Nine IO tiles of 4 bits; chain[35:32] is the deepest tile.
  always @(posedge clock) begin
    if (!config_nreset) chain <= '0;
    else if (config_enable) chain <= {chain[34:0], config_out};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s_ready", tag),  word_ready,    0);
    check($sformatf("%s_out", tag),    config_out,    0);
    check($sformatf("%s_enable", tag), config_enable, 0);
    check($sformatf("%s_nreset", tag), config_nreset, 0);
    check($sformatf("%s_busy", tag),   busy,          0);
    check($sformatf("%s_done", tag),   done,          0);
    check($sformatf("%s_count", tag),  bit_count,     0);
  endtask

  task automatic run_load(input string tag, input int stall_len, input int start_bc,
                          input int reset_bc, input int exp_gaps);
    int idx = 0, stall_left = stall_len, nrst_low = 0, en_cnt = 0, gaps = 0;
    bit pend = 0, pulsed = 0, finished = 0, aborted = 0;
    @(negedge clock);
    start      = 1'b1;
    word_valid = 1'b0;
    @(negedge clock);
    check($sformatf("%s_done_drop", tag), done, 0);
    check($sformatf("%s_busy_rise", tag), busy, 1);
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      if (cyc > 0) @(negedge clock);
      start = 1'b0;
      if (pend) idx++;
      if (!config_nreset) nrst_low++;
      if (config_enable) begin
        if (en_cnt < 36)
          check($sformatf("%s_bit%0d", tag, en_cnt), config_out, exp_stream[35 - en_cnt]);
        en_cnt++;
      end else if (busy && config_nreset && en_cnt > 0 && en_cnt <= 36) begin
        gaps++;
        check($sformatf("%s_hold%0d", tag, gaps), config_out, exp_stream[36 - en_cnt]);
      end
      if (done) begin
        finished = 1;
      end else if (reset_bc >= 0 && bit_count == 6'(reset_bc)) begin
        reset = 1'b1;
        #1;
        check_reset_outputs($sformatf("%s_midreset", tag));
        @(negedge clock);
        reset      = 1'b0;
        word_valid = 1'b0;
        aborted    = 1;
        finished   = 1;
      end else begin
        if (start_bc >= 0 && !pulsed && bit_count == 6'(start_bc)) begin
          start  = 1'b1;
          pulsed = 1;
        end
        if (idx == 2 && stall_left > 0 && word_ready) begin
          word_valid = 1'b0;
          stall_left--;
        end else begin
          word_valid = 1'b1;
          word_data  = (idx < 5) ? words[idx] : 8'hFF;
        end
        pend = word_valid && word_ready;
      end
    end
    if (!finished) check($sformatf("%s_timeout", tag), 0, 1);
    if (finished && !aborted) begin
      check($sformatf("%s_done", tag),       done,          1);
      check($sformatf("%s_busy", tag),       busy,          0);
      check($sformatf("%s_count", tag),      bit_count,     36);
      check($sformatf("%s_enable", tag),     config_enable, 0);
      check($sformatf("%s_ready", tag),      word_ready,    0);
      check($sformatf("%s_shifts", tag),     en_cnt,        36);
      check($sformatf("%s_clear_len", tag),  nrst_low,      2);
      check($sformatf("%s_gaps", tag),       gaps,          exp_gaps);
      check($sformatf("%s_words", tag),      idx,           5);
      check($sformatf("%s_chain", tag),      chain,         exp_stream);
      check($sformatf("%s_deep_tile", tag),  chain[35:32],  4'hA);
      repeat (3) @(negedge clock);
      check($sformatf("%s_done_hold", tag),  done,          1);
      check($sformatf("%s_count_hold", tag), bit_count,     36);
      check($sformatf("%s_no_accept", tag),  word_ready,    0);
      word_valid = 1'b0;
    end
  endtask

  initial begin
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    words[2] = 8'hFF;
    words[3] = 8'h00;
    words[4] = 8'h1E;
    // Stream order, first bit at the MSB: A5,3C,FF,00 LSB-first then 0,1,1,1.
    exp_stream = 36'hA53CFF007;

    reset      = 1'b1;
    start      = 1'b0;
    word_valid = 1'b0;
    word_data  = '0;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset_held");
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("reset_idle");

    run_load("base",   0, -1, -1, 0);
    run_load("reload", 0, -1, -1, 0);
    run_load("stall",  3, -1, -1, 3);
    run_load("start_mid", 0, 10, -1, 0);
    run_load("abort",  0, -1, 20, 0);
    check("abort_idle_nreset", config_nreset, 0);
    check("abort_idle_busy",   busy,          0);
    run_load("recover", 0, -1, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
